// File: rtl/adder_subtractor_unit_if.sv
// rtl/adder_subtractor_unit_if.sv - operand/result bundle for the adder-subtractor core
interface adder_subtractor_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout_add;
    logic             ovf_add;
    logic [WIDTH-1:0] diff;
    logic             cout_sub;
    logic             ovf_sub;

    modport master (
        output in_valid, a, b,
        input  out_valid, sum, cout_add, ovf_add, diff, cout_sub, ovf_sub
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, sum, cout_add, ovf_add, diff, cout_sub, ovf_sub
    );
endinterface

// File: rtl/adder_subtractor_unit.sv
// rtl/adder_subtractor_unit.sv - registered parallel ripple-carry adder and subtractor
module adder_subtractor_unit #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_subtractor_unit_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   c_add;
    logic [WIDTH:0]   c_sub;
    logic [WIDTH-1:0] s_add;
    logic [WIDTH-1:0] s_sub;
    logic [WIDTH-1:0] b_n;

    assign c_add[0] = 1'b0;
    assign c_sub[0] = 1'b1;
    assign b_n      = ~bus.b;

    // Two independent full-adder chains; subtraction is a + ~b + 1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign s_add[i]   = bus.a[i] ^ bus.b[i] ^ c_add[i];
        assign c_add[i+1] = (bus.a[i] & bus.b[i]) | (c_add[i] & (bus.a[i] ^ bus.b[i]));
        assign s_sub[i]   = bus.a[i] ^ b_n[i] ^ c_sub[i];
        assign c_sub[i+1] = (bus.a[i] & b_n[i]) | (c_sub[i] & (bus.a[i] ^ b_n[i]));
    end

    logic ovf_add_c;
    logic ovf_sub_c;

    assign ovf_add_c = (bus.a[MSB] == bus.b[MSB]) && (s_add[MSB] != bus.a[MSB]);
    assign ovf_sub_c = (bus.a[MSB] != bus.b[MSB]) && (s_sub[MSB] != bus.a[MSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout_add  <= 1'b0;
            bus.ovf_add   <= 1'b0;
            bus.diff      <= '0;
            bus.cout_sub  <= 1'b0;
            bus.ovf_sub   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum      <= s_add;
                bus.cout_add <= c_add[WIDTH];
                bus.ovf_add  <= ovf_add_c;
                bus.diff     <= s_sub;
                // Inverted carry of a + ~b + 1 is the borrow.
                bus.cout_sub <= ~c_sub[WIDTH];
                bus.ovf_sub  <= ovf_sub_c;
            end
        end
    end
endmodule

// File: tb/tb_adder_subtractor_unit.sv
// tb/tb_adder_subtractor_unit.sv - randomized model-checked bench for adder_subtractor_unit
module tb_adder_subtractor_unit;
    localparam int W   = 8;
    localparam int MOD = 2 ** W;
    localparam int HALF = 2 ** (W - 1);

    logic clk;
    logic rst;

    adder_subtractor_unit_if #(.WIDTH(W)) bus ();

    adder_subtractor_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_ov, m_sum, m_cadd, m_oadd, m_diff, m_csub, m_osub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    task automatic model_step(input bit r, input bit v, input int x, input int y);
        int sx, sy;
        if (r) begin
            m_ov = 0; m_sum = 0; m_cadd = 0; m_oadd = 0;
            m_diff = 0; m_csub = 0; m_osub = 0;
        end else begin
            m_ov = v;
            if (v) begin
                sx     = to_signed(x);
                sy     = to_signed(y);
                m_sum  = (x + y) % MOD;
                m_cadd = (x + y >= MOD) ? 1 : 0;
                m_diff = (x - y + MOD) % MOD;
                m_csub = (x < y) ? 1 : 0;
                m_oadd = (sx + sy >= HALF || sx + sy < -HALF) ? 1 : 0;
                m_osub = (sx - sy >= HALF || sx - sy < -HALF) ? 1 : 0;
            end
        end
    endtask

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("sum",       32'(bus.sum),       32'(m_sum));
            chk("cout_add",  32'(bus.cout_add),  32'(m_cadd));
            chk("ovf_add",   32'(bus.ovf_add),   32'(m_oadd));
            chk("diff",      32'(bus.diff),      32'(m_diff));
            chk("cout_sub",  32'(bus.cout_sub),  32'(m_csub));
            chk("ovf_sub",   32'(bus.ovf_sub),   32'(m_osub));
        end
    end

    task automatic step(input bit r, input bit v, input int x, input int y);
        rst          = r;
        bus.in_valid = v;
        bus.a        = W'(x);
        bus.b        = W'(y);
        @(posedge clk);
        model_step(r, v, x, y);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input int ov, input int s, input int ca, input int oa,
                       input int d, input int cs, input int os);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".sum"},       32'(bus.sum),       32'(s));
        chk({tag, ".cout_add"},  32'(bus.cout_add),  32'(ca));
        chk({tag, ".ovf_add"},   32'(bus.ovf_add),   32'(oa));
        chk({tag, ".diff"},      32'(bus.diff),      32'(d));
        chk({tag, ".cout_sub"},  32'(bus.cout_sub),  32'(cs));
        chk({tag, ".ovf_sub"},   32'(bus.ovf_sub),   32'(os));
    endtask

    int va[7]  = '{15, 0, 255, 10, 50, 255, 123};
    int vb[7]  = '{10, 0, 1, 15, 100, 255, 200};
    int es[7]  = '{25, 0, 0, 25, 150, 254, 67};
    int eca[7] = '{0, 0, 1, 0, 0, 1, 1};
    int eoa[7] = '{0, 0, 0, 0, 1, 0, 0};
    int ed[7]  = '{5, 0, 254, 251, 206, 0, 179};
    int ecs[7] = '{0, 0, 0, 1, 1, 0, 1};
    int eos[7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        m_ov = 0; m_sum = 0; m_cadd = 0; m_oadd = 0;
        m_diff = 0; m_csub = 0; m_osub = 0;

        step(1, 0, 0, 0);
        cmp_en = 1'b1;
        step(1, 1, 77, 33);
        step(0, 0, 99, 44);
        lit("reset", 0, 0, 0, 0, 0, 0, 0);

        // Isolated vectors, each followed by an idle cycle with changed operands.
        for (int i = 0; i < 7; i++) begin
            step(0, 1, va[i], vb[i]);
            lit($sformatf("vec%0d", i), 1, es[i], eca[i], eoa[i], ed[i], ecs[i], eos[i]);
            step(0, 0, 3, 200);
            lit($sformatf("hold%0d", i), 0, es[i], eca[i], eoa[i], ed[i], ecs[i], eos[i]);
        end

        for (int i = 0; i < 7; i++) begin
            step(0, 1, va[i], vb[i]);
            lit($sformatf("b2b%0d", i), 1, es[i], eca[i], eoa[i], ed[i], ecs[i], eos[i]);
        end
        step(0, 0, 1, 1);
        lit("b2b_drop", 0, 67, 1, 0, 179, 1, 1);
        step(0, 0, 2, 2);
        lit("b2b_hold", 0, 67, 1, 0, 179, 1, 1);

        step(1, 1, 255, 1);
        lit("rst_with_valid", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 255, 1);
        lit("after_rst_idle", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            int x, y, r, v;
            r = ($urandom_range(0, 49) == 0) ? 1 : 0;
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            case ($urandom_range(0, 7))
                0:       x = MOD - 1;
                1:       x = HALF;
                2:       x = HALF - 1;
                default: x = $urandom_range(0, MOD - 1);
            endcase
            case ($urandom_range(0, 7))
                0:       y = MOD - 1;
                1:       y = HALF;
                2:       y = 0;
                default: y = $urandom_range(0, MOD - 1);
            endcase
            step(r[0], v[0], x, y);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
